// File: rtl/fpu_pkg.sv
// Shared floating-point unit types: fmul latency, fp32 word and the in-flight tag.
package fpu_pkg;

    localparam int unsigned FMUL_LAT = 3;
    localparam int unsigned TAG_ID_W = 4;

    typedef logic [31:0] fp32_t;

    // Wide enough for up to 16 requesters; narrower ids are zero-extended.
    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fmul.sv
// Three-stage IEEE-754 single multiply, round-to-nearest-even, denormals flushed to zero.
module fmul
    import fpu_pkg::*;
(
    input  logic  clk,
    input  fp32_t x1,
    input  fp32_t x2,
    output fp32_t y
);

    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign a_zero = (x1[30:23] == 8'h00);
    assign b_zero = (x2[30:23] == 8'h00);
    assign a_inf  = (x1[30:23] == 8'hFF) && (x1[22:0] == '0);
    assign b_inf  = (x2[30:23] == 8'hFF) && (x2[22:0] == '0);
    assign a_nan  = (x1[30:23] == 8'hFF) && (x1[22:0] != '0);
    assign b_nan  = (x2[30:23] == 8'hFF) && (x2[22:0] != '0);

    logic              s1_sign, s1_zero, s1_inf, s1_nan;
    logic signed [9:0] s1_exp;
    logic [47:0]       s1_prod;

    always_ff @(posedge clk) begin
        s1_sign <= x1[31] ^ x2[31];
        s1_exp  <= $signed({2'b00, x1[30:23]}) + $signed({2'b00, x2[30:23]}) - 10'sd127;
        s1_prod <= {24'b0, 1'b1, x1[22:0]} * {24'b0, 1'b1, x2[22:0]};
        s1_nan  <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        s1_inf  <= a_inf | b_inf;
        s1_zero <= a_zero | b_zero;
    end

    logic [23:0]       n_m;
    logic              n_g, n_st;
    logic signed [9:0] n_e;

    always_comb begin
        if (s1_prod[47]) begin
            n_m  = s1_prod[47:24];
            n_g  = s1_prod[23];
            n_st = |s1_prod[22:0];
            n_e  = s1_exp + 10'sd1;
        end else begin
            n_m  = s1_prod[46:23];
            n_g  = s1_prod[22];
            n_st = |s1_prod[21:0];
            n_e  = s1_exp;
        end
    end

    logic              s2_sign, s2_zero, s2_inf, s2_nan, s2_g, s2_st;
    logic signed [9:0] s2_e;
    logic [23:0]       s2_m;

    always_ff @(posedge clk) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_inf  <= s1_inf;
        s2_nan  <= s1_nan;
        s2_m    <= n_m;
        s2_g    <= n_g;
        s2_st   <= n_st;
        s2_e    <= n_e;
    end

    logic              up;
    logic [24:0]       mr;
    logic signed [9:0] e_f;
    logic [22:0]       frac;
    fp32_t             r;

    always_comb begin
        up   = s2_g & (s2_st | s2_m[0]);
        mr   = {1'b0, s2_m} + 25'(up);
        e_f  = s2_e + $signed({9'b0, mr[24]});
        frac = mr[24] ? '0 : mr[22:0];
        if (s2_nan)
            r = 32'h7FC00000;
        else if (s2_inf || e_f >= 10'sd255)
            r = {s2_sign, 8'hFF, 23'b0};
        else if (s2_zero || e_f <= 10'sd0)
            r = {s2_sign, 31'b0};
        else
            r = {s2_sign, e_f[7:0], frac};
    end

    always_ff @(posedge clk) begin
        y <= r;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from ptr+1, pointer follows each accepted grant.
module rr_arbiter #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;
    logic [W-1:0] idx;
    logic         found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    // Reset pointer to the last index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= W'(N - 1);
        else if (advance)
            ptr <= gnt_idx;
    end

endmodule

// File: rtl/fmul_arbiter.sv
// Shares one pipelined fmul among N_REQ requesters with round-robin issue;
// a tag pipeline returns each product with its requester id.
module fmul_arbiter
    import fpu_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [N_REQ*32-1:0] req_x1,
    input  logic [N_REQ*32-1:0] req_x2,
    output logic              res_valid,
    output logic [ID_W-1:0]   res_id,
    output logic [31:0]       res_y,
    output logic [2:0]        inflight,
    output logic              idle
);

    localparam int unsigned MUL_LAT = FMUL_LAT;

    logic [N_REQ-1:0] arb_req, gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             xfer;
    fp32_t            sel_x1, sel_x2;

    assign arb_req   = req_valid & {N_REQ{~(hold | rst)}};
    assign req_ready = gnt;
    assign xfer      = |gnt;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // AND-OR select keeps X on unselected lanes out of the datapath.
    always_comb begin
        sel_x1 = '0;
        sel_x2 = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sel_x1 = sel_x1 | (req_x1[32*i +: 32] & {32{gnt[i]}});
            sel_x2 = sel_x2 | (req_x2[32*i +: 32] & {32{gnt[i]}});
        end
    end

    logic            iss_v;
    logic [ID_W-1:0] iss_id;
    fp32_t           iss_x1, iss_x2;

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_v  <= 1'b0;
            iss_id <= '0;
        end else begin
            iss_v  <= xfer;
            iss_id <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            iss_x1 <= sel_x1;
            iss_x2 <= sel_x2;
        end
    end

    fmul u_fmul (
        .clk (clk),
        .x1  (iss_x1),
        .x2  (iss_x2),
        .y   (res_y)
    );

    tag_t tags [MUL_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < MUL_LAT; k++)
                tags[k] <= '0;
        end else begin
            tags[0] <= '{v: iss_v, id: TAG_ID_W'(iss_id)};
            for (int unsigned k = 1; k < MUL_LAT; k++)
                tags[k] <= tags[k-1];
        end
    end

    logic tag_id_unused;
    assign tag_id_unused = ^tags[MUL_LAT-1].id;

    assign res_valid = tags[MUL_LAT-1].v;
    assign res_id    = tags[MUL_LAT-1].id[ID_W-1:0];

    always_ff @(posedge clk) begin
        if (rst)
            inflight <= '0;
        else
            inflight <= inflight + 3'(xfer) - 3'(res_valid);
    end

    assign idle = (inflight == 3'd0);

endmodule
